des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
- Sequential DES round-key generator feeding the round datapath that consumes the S-box substitution stages.
- Takes a 64-bit key and emits the 16 48-bit subkeys one per valid/ready handshake.
- Emits in encryption order (K1..K16) or decryption order (K16..K1), so one round datapath serves both directions.
- Uses one 28+28-bit C/D register pair with left/right rotation; no 16-entry key store.

Parameters:
- SHIFT_SCHEDULE, 16'h8103, bit r-1 = 1 means round r rotates by 1, otherwise by 2. Default gives single shifts in rounds 1, 2, 9, 16.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a schedule; sampled only in IDLE
- decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled with start
- key_in  input  64  DES key; key_in[63] is DES bit 1; bits 8,16,..,64 are parity
- subkey_ready  input  1  consumer accepts subkey this cycle
- subkey_valid  output  1  subkey/round_idx valid
- subkey  output  48  PC-2 output; subkey[47] is DES bit 1
- round_idx  output  4  round number of current subkey minus 1 (K1 = 0, K16 = 15)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last handshake
- key_err  output  1  parity error flag (see Optional Feature)

Behaviour:
- Reset values:
  - subkey_valid, done, busy, key_err = 0
  - subkey = 0, round_idx = 0
  - C = D = 0, state = IDLE
- States are IDLE, LOAD, EMIT, FIN.
- IDLE:
  - On start: capture PC-1(key_in) into C/D and latch decrypt into dir_q.
  - Go to LOAD and set the internal round counter to 0.
  - start in any other state is ignored.
- LOAD (one cycle):
  - Encrypt: C/D rotate left by shift(1), then subkey <= PC-2 of the rotated C/D.
  - Decrypt: no rotation; subkey <= PC-2(C0,D0), which is K16.
  - Set subkey_valid = 1 and go to EMIT.
  - Latency: start at cycle N gives subkey_valid at N+2.
- EMIT:
  - subkey, round_idx and subkey_valid hold stable while subkey_ready = 0.
  - On valid && ready with counter < 15:
    - Increment counter.
    - Encrypt: rotate C/D left by shift(counter+1).
    - Decrypt: rotate right by shift(16-counter) for the key just sent.
    - Register the next PC-2 result on the same edge, so valid stays high.
    - Back-to-back ready gives one subkey per cycle.
  - On the handshake with counter = 15: subkey_valid <= 0, go to FIN.
- FIN: done = 1 for exactly one cycle, then IDLE. start during FIN is ignored.
- Rotations are modulo 28 on C and D independently; round_idx = r-1 for the subkey currently shown.
- rst asserted in any state, including mid-EMIT with valid high: next cycle all outputs are at reset values and state is IDLE. No partial done pulse.
- Inputs changing after the start cycle have no effect on the running schedule.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN
- Defined:
  - In IDLE on start, each key byte is checked for odd parity.
  - Any failing byte: key_err <= 1, go directly to FIN. done pulses at N+1, no subkey is emitted and C/D is not loaded.
  - key_err holds until the next accepted start or rst.
- Not defined:
  - key_err is tied to 0 and parity bits are ignored by PC-1, which discards them anyway.

Test Plan:
- Encrypt, key 64'h133457799BBCDFF1, ready held 1:
  - valid at N+2, first subkey 48'h1B02EFFC7072 with round_idx 0.
  - Last subkey 48'hCB3D8B0E17F5 with round_idx 15.
  - done pulse on the cycle after the 16th handshake; 16 consecutive valid cycles.
- Decrypt, same key: first subkey 48'hCB3D8B0E17F5 (round_idx 15), last 48'h1B02EFFC7072 (round_idx 0). The sequence must equal the encrypt sequence reversed.
- Backpressure: ready toggles 1,0,0,1 repeatedly.
  - subkey and round_idx stay stable while ready = 0.
  - Exactly 16 handshakes, with no skipped or duplicated index.
- Reset mid-schedule: assert rst during round_idx 5 with valid high.
  - Next cycle: valid = 0, busy = 0, subkey = 0, no done pulse.
  - A fresh start then reproduces the first test's sequence.
- start pulsed while busy with key 64'h0: ignored, and the running sequence is unchanged.
- With DES_KEY_PARITY_CHECK_EN, key 64'h123457799BBCDFF1 (byte 0x12 has even parity):
  - key_err = 1, done at N+1, subkey_valid never rises.
  - Key 64'h133457799BBCDFF1 runs with key_err = 0.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// Handshake and bus bundle between a DES round datapath and the key schedule.
// master drives the command and consumer-ready side.
// slave (the key schedule) drives subkeys and status.
interface des_key_schedule_if;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic        subkey_ready;
  logic        subkey_valid;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        key_err;

  modport master (
    output start, decrypt, key_in, subkey_ready,
    input  subkey_valid, subkey, round_idx, busy, done, key_err
  );

  modport slave (
    input  start, decrypt, key_in, subkey_ready,
    output subkey_valid, subkey, round_idx, busy, done, key_err
  );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: one C/D pair, rotated left (encrypt) or right (decrypt).
// Latency: start at cycle N gives the first subkey at N+2, then one subkey per accepted handshake.
// Backpressure: subkey/round_idx hold while subkey_ready is low. Optional macro DES_KEY_PARITY_CHECK_EN.
module des_key_schedule #(
  parameter logic [15:0] SHIFT_SCHEDULE = 16'h8103
) (
  input logic            clk,
  input logic            rst,
  des_key_schedule_if.slave bus
);

  // Permutation tables in DES bit numbering (bit 1 is the MSB).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_t;

  state_t      state, state_nxt;
  logic [27:0] c_q, d_q, c_nxt, d_nxt;
  logic [55:0] cd_load;
  logic        dir_q;
  logic [3:0]  cnt_q;
  logic        vld_q;
  logic [47:0] subkey_q;
  logic [3:0]  idx_q;
  logic        hs;
  logic        parity_bad;
  logic        busy_c, done_c;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) r[6'(55 - j)] = k[6'(64 - PC1[j])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[6'(47 - j)] = cd[6'(56 - PC2[j])];
    return r;
  endfunction

  // True when round r (1..16) rotates by a single bit.
  function automatic logic single_shift(input logic [4:0] r);
    logic [4:0] i;
    i = r - 5'd1;
    return SHIFT_SCHEDULE[i[3:0]];
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  assign cd_load = pc1(bus.key_in);
  assign hs      = vld_q & bus.subkey_ready;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic key_err_q;

  // Any key byte with even parity rejects the start.
  always_comb begin
    parity_bad = 1'b0;
    for (int b = 0; b < 8; b++) parity_bad = parity_bad | ~(^bus.key_in[6'(8 * b) +: 8]);
  end

  // Error flag is refreshed on every accepted start and held otherwise.
  always_ff @(posedge clk) begin
    if (rst)                              key_err_q <= 1'b0;
    else if (state == IDLE && bus.start)  key_err_q <= parity_bad;
  end

  assign bus.key_err = key_err_q;
`else
  assign parity_bad  = 1'b0;
  assign bus.key_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; EMIT leaves only on the sixteenth handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = parity_bad ? FIN : LOAD;
      LOAD: state_nxt = EMIT;
      EMIT: if (hs && cnt_q == 4'd15) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    busy_c = (state != IDLE);
    done_c = (state == FIN);
  end

  // Next C/D: encrypt steps forward to the following round, decrypt undoes the round just shown.
  always_comb begin
    c_nxt = c_q;
    d_nxt = d_q;
    if (state == LOAD && !dir_q) begin
      c_nxt = rotl(c_q, single_shift(5'd1));
      d_nxt = rotl(d_q, single_shift(5'd1));
    end else if (state == EMIT && !dir_q) begin
      c_nxt = rotl(c_q, single_shift({1'b0, cnt_q} + 5'd2));
      d_nxt = rotl(d_q, single_shift({1'b0, cnt_q} + 5'd2));
    end else if (state == EMIT && dir_q) begin
      c_nxt = rotr(c_q, single_shift(5'd16 - {1'b0, cnt_q}));
      d_nxt = rotr(d_q, single_shift(5'd16 - {1'b0, cnt_q}));
    end
  end

  // Datapath: load C/D on start, register each subkey alongside its round index.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q      <= '0;
      d_q      <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      subkey_q <= '0;
      idx_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !parity_bad) begin
            c_q   <= cd_load[55:28];
            d_q   <= cd_load[27:0];
            dir_q <= bus.decrypt;
            cnt_q <= '0;
          end
        end
        LOAD: begin
          c_q      <= c_nxt;
          d_q      <= d_nxt;
          subkey_q <= pc2({c_nxt, d_nxt});
          idx_q    <= dir_q ? 4'd15 : 4'd0;
          vld_q    <= 1'b1;
        end
        EMIT: begin
          if (hs) begin
            if (cnt_q != 4'd15) begin
              cnt_q    <= cnt_q + 4'd1;
              c_q      <= c_nxt;
              d_q      <= d_nxt;
              subkey_q <= pc2({c_nxt, d_nxt});
              idx_q    <= dir_q ? idx_q - 4'd1 : idx_q + 4'd1;
            end else begin
              vld_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.subkey_valid = vld_q;
  assign bus.subkey       = subkey_q;
  assign bus.round_idx    = idx_q;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;

endmodule
